// File: rtl/divrem_sequencer_pkg.sv
// Shared definitions for the sequential divide/remainder unit: width, status bit
// positions, FSM encoding and the status-word builder.
package divrem_sequencer_pkg;

    localparam int DRS_WIDTH = 32;

    localparam int ST_NEG      = 0;
    localparam int ST_ZERO     = 1;
    localparam int ST_CARRY    = 2;
    localparam int ST_OVERFLOW = 3;

    typedef enum logic [1:0] {
        DRS_IDLE = 2'd0,
        DRS_CALC = 2'd1,
        DRS_DONE = 2'd2
    } drs_state_e;

    // Status word in the common ALU layout {overflow, carry, zero, neg}.
    function automatic logic [3:0] drs_status(input logic neg, input logic zero, input logic ovf);
        logic [3:0] st;
        st              = 4'b0000;
        st[ST_NEG]      = neg;
        st[ST_ZERO]     = zero;
        st[ST_CARRY]    = 1'b0;
        st[ST_OVERFLOW] = ovf;
        return st;
    endfunction

endpackage

// File: rtl/divrem_step.sv
// One restoring shift-subtract step: shift the next dividend bit into the partial
// remainder and subtract the divisor when it fits.
module divrem_step
    import divrem_sequencer_pkg::*;
#(
    parameter int WIDTH = DRS_WIDTH
) (
    input  logic [WIDTH-1:0] rem_in,
    input  logic             dvd_msb,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_out,
    output logic             q_bit
);

    logic [WIDTH:0] shifted_s;

    // The shifted remainder can briefly need WIDTH+1 bits, so compare at that width.
    always_comb begin
        shifted_s = {rem_in, dvd_msb};
        if (shifted_s >= {1'b0, divisor}) begin
            q_bit   = 1'b1;
            rem_out = WIDTH'(shifted_s - {1'b0, divisor});
        end else begin
            q_bit   = 1'b0;
            rem_out = shifted_s[WIDTH-1:0];
        end
    end

endmodule

// File: rtl/divrem_sequencer.sv
// Multi-cycle unsigned divide/remainder unit: valid/ready operand intake, one
// restoring step per clock, registered result and status with backpressure.
module divrem_sequencer
    import divrem_sequencer_pkg::*;
#(
    parameter int WIDTH = DRS_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             op_sel,
    input  logic [WIDTH-1:0] operand1,
    input  logic [WIDTH-1:0] operand2,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [3:0]       statusOut,
    output logic             busy
);

    localparam int CNT_W = $clog2(WIDTH) + 1;

    drs_state_e       state_r, state_s;
    logic [WIDTH-1:0] dvd_r, dvs_r, rem_r, quot_r;
    logic [CNT_W-1:0] cnt_r;
    logic             op_r, dbz_r;
    logic [WIDTH-1:0] step_rem_s, sel_s;
    logic             step_q_s, emit_s, release_s;
    logic             in_ready_r, out_valid_r, busy_r;
    logic [WIDTH-1:0] result_r;
    logic [3:0]       status_r;

    divrem_step #(.WIDTH(WIDTH)) u_step (
        .rem_in  (rem_r),
        .dvd_msb (dvd_r[WIDTH-1]),
        .divisor (dvs_r),
        .rem_out (step_rem_s),
        .q_bit   (step_q_s)
    );

    // Output stage loads one cycle after DONE is entered; release is the consumer handshake.
    always_comb begin
        sel_s     = op_r ? quot_r : rem_r;
        emit_s    = (state_r == DRS_DONE) && !out_valid_r;
        release_s = out_valid_r && out_ready;
    end

    // Next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            DRS_IDLE: begin
                if (in_valid) begin
                    state_s = (operand2 == {WIDTH{1'b0}}) ? DRS_DONE : DRS_CALC;
                end else begin
                    state_s = DRS_IDLE;
                end
            end
            DRS_CALC: begin
                if (cnt_r == CNT_W'(1)) begin
                    state_s = DRS_DONE;
                end else begin
                    state_s = DRS_CALC;
                end
            end
            DRS_DONE: begin
                if (release_s) begin
                    state_s = DRS_IDLE;
                end else begin
                    state_s = DRS_DONE;
                end
            end
            default: state_s = DRS_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= DRS_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Operand capture and shift-subtract datapath; a zero divisor preloads the final answers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dvd_r  <= {WIDTH{1'b0}};
            dvs_r  <= {WIDTH{1'b0}};
            rem_r  <= {WIDTH{1'b0}};
            quot_r <= {WIDTH{1'b0}};
            cnt_r  <= {CNT_W{1'b0}};
            op_r   <= 1'b0;
            dbz_r  <= 1'b0;
        end else begin
            case (state_r)
                DRS_IDLE: begin
                    if (in_valid) begin
                        dvd_r <= operand1;
                        dvs_r <= operand2;
                        op_r  <= op_sel;
                        cnt_r <= CNT_W'(WIDTH);
                        if (operand2 == {WIDTH{1'b0}}) begin
                            quot_r <= {WIDTH{1'b1}};
                            rem_r  <= operand1;
                            dbz_r  <= 1'b1;
                        end else begin
                            quot_r <= {WIDTH{1'b0}};
                            rem_r  <= {WIDTH{1'b0}};
                            dbz_r  <= 1'b0;
                        end
                    end
                end
                DRS_CALC: begin
                    rem_r  <= step_rem_s;
                    quot_r <= {quot_r[WIDTH-2:0], step_q_s};
                    dvd_r  <= {dvd_r[WIDTH-2:0], 1'b0};
                    cnt_r  <= cnt_r - CNT_W'(1);
                end
                default: begin
                    cnt_r <= cnt_r;
                end
            endcase
        end
    end

    // Registered handshake flags, result and status.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            in_ready_r  <= 1'b1;
            busy_r      <= 1'b0;
            out_valid_r <= 1'b0;
            result_r    <= {WIDTH{1'b0}};
            status_r    <= 4'b0000;
        end else begin
            in_ready_r <= (state_s == DRS_IDLE);
            busy_r     <= (state_s != DRS_IDLE);
            if (emit_s) begin
                out_valid_r <= 1'b1;
                result_r    <= sel_s;
                status_r    <= drs_status(sel_s[WIDTH-1], sel_s == {WIDTH{1'b0}}, dbz_r);
            end else if (release_s) begin
                out_valid_r <= 1'b0;
                result_r    <= {WIDTH{1'b0}};
                status_r    <= 4'b0000;
            end
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign busy      = busy_r;
    assign result    = result_r;
    assign statusOut = status_r;

endmodule

// File: tb/tb_divrem_sequencer.sv
// Directed and randomized check of divrem_sequencer against a plain-arithmetic
// reference model (/ and % with the zero-divisor rules).
module tb_divrem_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        op_sel = 1'b0;
    logic [31:0] operand1 = 32'd0;
    logic [31:0] operand2 = 32'd0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] result;
    logic [3:0]  statusOut;
    logic        busy;

    int total = 0;
    int fails = 0;

    always #5 clk = ~clk;

    divrem_sequencer dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op_sel    (op_sel),
        .operand1  (operand1),
        .operand2  (operand2),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .statusOut (statusOut),
        .busy      (busy)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // status = {overflow, carry, zero, neg}
    function automatic void ref_model(input logic op, input logic [31:0] a, input logic [31:0] b,
                                      output logic [31:0] r, output logic [3:0] st);
        if (b == 32'd0) r = op ? 32'hFFFF_FFFF : a;
        else            r = op ? a / b : a % b;
        st = {(b == 32'd0), 1'b0, (r == 32'd0), r[31]};
    endfunction

    task automatic run_txn(input string tag, input logic op, input logic [31:0] a,
                           input logic [31:0] b, input int hold);
        logic [31:0] er;
        logic [3:0]  es;
        int          lat;
        int          wait_n;
        ref_model(op, a, b, er, es);
        wait_n = 0;
        while (!in_ready && wait_n < 100) begin
            @(posedge clk); #1;
            wait_n++;
        end
        check({tag, ":in_ready"}, in_ready, 1);
        in_valid = 1'b1; op_sel = op; operand1 = a; operand2 = b;
        @(posedge clk); #1;
        in_valid = 1'b0; op_sel = ~op; operand1 = $urandom; operand2 = $urandom;
        check({tag, ":busy"}, busy, 1);
        lat = 0;
        while (!out_valid && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
        check({tag, ":latency"}, lat, (b == 32'd0) ? 1 : 33);
        check({tag, ":result"}, result, er);
        check({tag, ":status"}, statusOut, es);
        for (int h = 0; h < hold; h++) begin
            in_valid = (h == 3); op_sel = 1'b1; operand1 = 32'd5; operand2 = 32'd1;
            @(posedge clk); #1;
            in_valid = 1'b0;
            check({tag, ":hold_result"}, result, er);
            check({tag, ":hold_valid"}, out_valid, 1);
            check({tag, ":hold_ready"}, in_ready, 0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check({tag, ":released"}, out_valid, 0);
        check({tag, ":status_cleared"}, statusOut, 0);
        check({tag, ":ready_again"}, in_ready, 1);
    endtask

    initial begin
        // Reset values while rst is held
        @(posedge clk); #1;
        check("reset:in_ready", in_ready, 1);
        check("reset:out_valid", out_valid, 0);
        check("reset:busy", busy, 0);
        check("reset:result", result, 0);
        check("reset:status", statusOut, 0);
        rst = 1'b0;
        @(posedge clk); #1;

        run_txn("t1_17rem5", 1'b0, 32'd17, 32'd5, 0);
        run_txn("t2_17quot5", 1'b1, 32'd17, 32'd5, 0);
        run_txn("t2_5quot17", 1'b1, 32'd5, 32'd17, 0);
        run_txn("t2_5rem17", 1'b0, 32'd5, 32'd17, 0);
        run_txn("t3_dbz_quot", 1'b1, 32'h1234, 32'd0, 0);
        run_txn("t3_dbz_rem", 1'b0, 32'h1234, 32'd0, 0);
        run_txn("t4_rem_msb", 1'b0, 32'hFFFF_FFFF, 32'h8000_0000, 0);
        run_txn("t4_quot_one", 1'b1, 32'hFFFF_FFFF, 32'd1, 0);
        run_txn("t5_backpressure", 1'b1, 32'd1000, 32'd7, 10);
        run_txn("t5_after", 1'b0, 32'd1000, 32'd7, 0);

        // Reset in the middle of a calculation
        in_valid = 1'b1; op_sel = 1'b0; operand1 = 32'd12345; operand2 = 32'd7;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (5) begin @(posedge clk); #1; end
        check("t6:busy_before", busy, 1);
        rst = 1'b1;
        #1;
        check("t6:in_ready", in_ready, 1);
        check("t6:out_valid", out_valid, 0);
        check("t6:busy", busy, 0);
        check("t6:result", result, 0);
        check("t6:status", statusOut, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        check("t6:no_late_valid", out_valid, 0);
        run_txn("t6_100rem7", 1'b0, 32'd100, 32'd7, 0);

        // Randomized pairs with biased divisors
        for (int n = 0; n < 1500; n++) begin
            logic [31:0] a, b;
            int          k;
            k = $urandom_range(0, 9);
            a = $urandom;
            b = $urandom;
            if (k == 0)      b = 32'd0;
            else if (k <= 3) b = $urandom_range(1, 255);
            else if (k == 4) a = $urandom_range(0, 1000);
            run_txn("rand", 1'($urandom_range(0, 1)), a, b, 0);
        end

        $display("%0d/%0d checks passed", total - fails, total);
        $finish;
    end

endmodule
